outport_uart_tx: RTL and testbench
==================================

Name: outport_uart_tx

Overview:
Peripheral on the far side of the Mini-SRC OutPort.
- Accepts 32-bit words written by the CPU's OutPortin cycle and buffers them in a small FIFO.
- Serialises each word as four 8N1 UART bytes on a single tx line.
- Returns a status word that the CPU can route into InPort_input and poll with an `in` instruction, giving software flow control.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit; legal range 2..65535.
FIFO_DEPTH, 4, word FIFO entries; must be a power of two, 2..16.

Ports:
clock  input  1  system clock; all logic on the rising edge.
clear  input  1  reset, synchronous and active-low.
out_wr  input  1  one-cycle write strobe; driven by the same signal as OutPortin.
out_data  input  32  word to transmit; sampled when out_wr=1.
tx  output  1  UART serial line; idle high.
busy  output  1  1 while a frame is in flight or the FIFO is non-empty.
fifo_full  output  1  FIFO holds FIFO_DEPTH words.
fifo_count  output  5  number of words currently stored.
overflow  output  1  sticky; set when a write is dropped.
status_word  output  32  {24'd0, overflow, fifo_full, busy, fifo_count}, for InPort_input.

Behaviour:
- Reset (clear=0 at a rising edge):
  - tx=1, busy=0, fifo_full=0, fifo_count=0, overflow=0.
  - FSM goes to IDLE and the FIFO pointers are zeroed.
  - Applies mid-frame: tx returns high on the next edge and buffered words are discarded.
- Write acceptance:
  - out_wr=1 with FIFO not full: out_data is pushed; fifo_count increments at that edge.
  - out_wr=1 with FIFO full and no pop in the same cycle: data is dropped and overflow is set (sticky until reset).
  - Simultaneous push and pop: both happen and fifo_count is unchanged. This includes the full case; the write is then accepted.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into a 32-bit shift word, set byte_idx=0 and go to START at the same edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
  - DATA: tx = current byte bit[bit_idx], LSB first, each bit CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - byte_idx<3: byte_idx++, next byte, go to START with no gap.
    - byte_idx==3, FIFO non-empty: pop the next word and go to START directly.
    - byte_idx==3, FIFO empty: go to IDLE.
- Byte order: out_data[7:0] is sent first, then [15:8], [23:16], [31:24].
- Latency:
  - A write sampled at edge k into an empty FIFO with the FSM idle sets fifo_count=1 after edge k.
  - The pop occurs at edge k+1 and tx=0 from edge k+1.
- Frame timing:
  - One byte takes 10*CLKS_PER_BIT cycles; one word takes 40*CLKS_PER_BIT cycles.
  - Back-to-back words have no idle cycles between them.
- Baud counter: counts 0..CLKS_PER_BIT-1, restarts on every state change, and is 16 bits wide.
- fifo_count counts FIFO entries only; the word in the shift register is not included.
- busy = (state!=IDLE) | (fifo_count!=0).

Optional Feature:
Macro: OUTPORT_UART_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = even parity, i.e. XOR of the 8 data bits, for CLKS_PER_BIT cycles.
  - A byte takes 11*CLKS_PER_BIT cycles; a word takes 44*CLKS_PER_BIT.
- Undefined: PARITY state and logic are absent; the frame is 8N1 as above.

Decomposition:
- Package mini_src_io_pkg:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - BYTES_PER_WORD=4, DATA_BITS=8.
  - Status-word bit positions: OVF_BIT=7, FULL_BIT=6, BUSY_BIT=5, COUNT_LSB=0.
- Sub-module word_fifo: synchronous FIFO with parameter FIFO_DEPTH.
  - Ports: push, pop, din, dout, count, full, empty.
  - Same clock/clear convention as the parent.
  - Simultaneous push/pop allowed when full.
- Top level: FSM, baud counter, shift word, status word.

Test Plan:
- Reset mid-frame: assert clear=0 for 1 cycle 50 cycles into a word -> tx=1, fifo_count=0, busy=0 next cycle; remaining bytes never sent.
- Single word, CLKS_PER_BIT=4: write 0x000000A5 -> tx=0 from edge k+1.
  - First byte bits 1,0,1,0,0,1,0,1, each 4 cycles, then stop.
  - Then three 0x00 bytes.
  - busy drops exactly 160 cycles after the pop.
- Byte order: write 0x44332211 -> bytes observed 0x11, 0x22, 0x33, 0x44 in that order.
- Overflow, FIFO_DEPTH=4: 6 consecutive writes while idle -> first popped, 4 stored (fifo_count=4, fifo_full=1), 6th dropped, overflow=1, status_word=0x000000E4.
- Back-to-back: two writes 0xFFFFFFFF, 0x00000000 -> second word's start bit immediately follows the first word's final stop bit; total busy time 320 cycles.
- Parity build, with the macro defined: write 0x00000007 -> first byte parity bit=1, other bytes parity=0; word length 176 cycles.

Source files
------------

// File: rtl/mini_src_io_pkg.sv
// Shared types and constants for the Mini-SRC OutPort UART transmitter.
package mini_src_io_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int DATA_BITS      = 8;
    localparam int COUNT_W        = 5;

    localparam int OVF_BIT   = 7;
    localparam int FULL_BIT  = 6;
    localparam int BUSY_BIT  = 5;
    localparam int COUNT_LSB = 0;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/outport_uart_tx_if.sv
// CPU-facing bundle: write strobe/data in, serial line and status out.
interface outport_uart_tx_if;
    logic        out_wr;
    logic [31:0] out_data;
    logic        tx;
    logic        busy;
    logic        fifo_full;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic [31:0] status_word;

    modport master (
        output out_wr, out_data,
        input  tx, busy, fifo_full, fifo_count, overflow, status_word
    );

    modport slave (
        input  out_wr, out_data,
        output tx, busy, fifo_full, fifo_count, overflow, status_word
    );
endinterface

// File: rtl/outport_uart_tx_word_fifo.sv
// Synchronous word FIFO; a push while full is accepted when a pop happens in the same cycle.
module word_fifo
    import mini_src_io_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               push,
    input  logic               pop,
    input  logic [31:0]        din,
    output logic [31:0]        dout,
    output logic [COUNT_W-1:0] count,
    output logic               full,
    output logic               empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [31:0]        mem_q [FIFO_DEPTH];
    logic               push_ok, pop_ok;

    always_comb begin
        full     = (count_q == COUNT_W'(FIFO_DEPTH));
        empty    = (count_q == {COUNT_W{1'b0}});
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + COUNT_W'(1);
            2'b01:   count_d = count_q - COUNT_W'(1);
            default: count_d = count_q;
        endcase
        dout  = mem_q[rd_ptr_q];
        count = count_q;
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {COUNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/outport_uart_tx.sv
// OutPort UART transmitter: buffers CPU words and sends each as four LSB-first bytes.
// Define OUTPORT_UART_PARITY_EN to add an even-parity bit after each byte's data bits.
module outport_uart_tx
    import mini_src_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic               clock,
    input  logic               clear,
    outport_uart_tx_if.slave   bus
);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

    uart_state_e        state_q, state_d;
    logic [15:0]        baud_q, baud_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [31:0]        shift_q, shift_d;
    logic               overflow_q, overflow_d;
    logic               tx_q, tx_d;

    logic               fifo_pop;
    logic [31:0]        fifo_dout;
    logic [COUNT_W-1:0] fifo_count;
    logic               fifo_full, fifo_empty;
    logic               baud_done;

    word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .clear (clear),
        .push  (bus.out_wr),
        .pop   (fifo_pop),
        .din   (bus.out_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Frame sequencer: baud timing, bit/byte stepping and FIFO pops.
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        fifo_pop   = 1'b0;
        baud_done  = (baud_q == BAUD_LAST);
        baud_d     = baud_done ? 16'd0 : baud_q + 16'd1;
        overflow_d = overflow_q | (bus.out_wr & fifo_full & ~fifo_pop);

        case (state_q)
            IDLE: begin
                baud_d = 16'd0;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_dout;
                    byte_idx_d = 2'd0;
                    state_d    = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (baud_done) begin
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (baud_done && bit_idx_q == LAST_BIT) begin
`ifdef OUTPORT_UART_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end else if (baud_done) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    state_d = DATA;
                end
            end
`ifdef OUTPORT_UART_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    state_d = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
`endif
            STOP: begin
                if (!baud_done) begin
                    state_d = STOP;
                end else if (byte_idx_q != LAST_BYTE) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    shift_d    = shift_q >> DATA_BITS;
                    state_d    = START;
                end else if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_dout;
                    byte_idx_d = 2'd0;
                    state_d    = START;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                baud_d  = 16'd0;
                state_d = IDLE;
            end
        endcase

        // A pop frees a slot, so a concurrent write into a full FIFO is not lost.
        overflow_d = overflow_q | (bus.out_wr & fifo_full & ~fifo_pop);

        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[bit_idx_d];
`ifdef OUTPORT_UART_PARITY_EN
            PARITY:  tx_d = even_parity(shift_d[7:0]);
`endif
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // Sequencer and line registers.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q    <= IDLE;
            baud_q     <= 16'd0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 2'd0;
            shift_q    <= 32'd0;
            overflow_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            overflow_q <= overflow_d;
            tx_q       <= tx_d;
        end
    end

    // Status outputs, all derived from registered state.
    always_comb begin
        bus.tx          = tx_q;
        bus.busy        = (state_q != IDLE) | (fifo_count != {COUNT_W{1'b0}});
        bus.fifo_full   = fifo_full;
        bus.fifo_count  = fifo_count;
        bus.overflow    = overflow_q;
        bus.status_word = 32'd0;
        bus.status_word[OVF_BIT]                 = overflow_q;
        bus.status_word[FULL_BIT]                = fifo_full;
        bus.status_word[BUSY_BIT]                = bus.busy;
        bus.status_word[COUNT_LSB +: COUNT_W]    = fifo_count;
    end

endmodule

// File: tb/tb_outport_uart_tx.sv
// Directed bench for outport_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4); honours OUTPORT_UART_PARITY_EN.
module tb_outport_uart_tx;
    import mini_src_io_pkg::*;

    localparam int N     = 4;
    localparam int DEPTH = 4;
`ifdef OUTPORT_UART_PARITY_EN
    localparam int BYTE_CYC = 11 * N;
`else
    localparam int BYTE_CYC = 10 * N;
`endif
    localparam int WORD_CYC = 4 * BYTE_CYC;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  b0, b1, b2, b3;
        logic [3:0]  par;
    } vec_t;

    logic clock = 1'b0;
    logic clear = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic cap_tx   [0:511];
    logic cap_busy [0:511];
    logic exp_tx   [0:511];

    outport_uart_tx_if bus ();

    outport_uart_tx #(.CLKS_PER_BIT(N), .FIFO_DEPTH(DEPTH)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [31:0] d);
        bus.out_wr   = 1'b1;
        bus.out_data = d;
        tick();
        bus.out_wr   = 1'b0;
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            cap_tx[i]   = bus.tx;
            cap_busy[i] = bus.busy;
            tick();
        end
    endtask

    // Ideal line waveform for one word starting at cycle offset base.
    task automatic build_expected(input logic [31:0] w, input int base);
        logic [7:0] b;
        int off;
        for (int j = 0; j < 4; j++) begin
            b   = w[8*j +: 8];
            off = base + j * BYTE_CYC;
            for (int c = 0; c < N; c++) begin
                exp_tx[off + c] = 1'b0;
                for (int k = 0; k < 8; k++) exp_tx[off + N*(1+k) + c] = b[k];
`ifdef OUTPORT_UART_PARITY_EN
                exp_tx[off + 9*N + c] = ^b;
`endif
                exp_tx[off + BYTE_CYC - N + c] = 1'b1;
            end
        end
    endtask

    task automatic compare_wave(input string name, input int n);
        int first;
        first = -1;
        for (int i = 0; i < n; i++) begin
            if (cap_tx[i] !== exp_tx[i] && first < 0) first = i;
        end
        check(name, 32'(first), 32'hFFFF_FFFF);
    endtask

    function automatic logic [7:0] decode_byte(input int j);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = cap_tx[j*BYTE_CYC + N*(1+k) + N/2];
        return b;
    endfunction

    vec_t vecs [5];

    initial begin
        int busy_cycles;
        int activity;
        logic [7:0] exp_b;

        vecs[0] = '{32'h0000_00A5, 8'hA5, 8'h00, 8'h00, 8'h00, 4'b0000};
        vecs[1] = '{32'h4433_2211, 8'h11, 8'h22, 8'h33, 8'h44, 4'b0000};
        vecs[2] = '{32'hDEAD_BEEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 4'b0101};
        vecs[3] = '{32'h0000_0007, 8'h07, 8'h00, 8'h00, 8'h00, 4'b0001};
        vecs[4] = '{32'h8000_0001, 8'h01, 8'h00, 8'h00, 8'h80, 4'b1001};

        bus.out_wr   = 1'b0;
        bus.out_data = 32'd0;
        clear        = 1'b0;
        repeat (3) tick();
        check("reset_tx", 32'(bus.tx), 32'd1);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_full", 32'(bus.fifo_full), 32'd0);
        check("reset_count", 32'(bus.fifo_count), 32'd0);
        check("reset_ovf", 32'(bus.overflow), 32'd0);
        check("reset_status", bus.status_word, 32'd0);
        clear = 1'b1;
        tick();

        // Latency: count=1 right after the write edge, start bit from the next edge.
        do_write(32'h0000_00A5);
        check("lat_count_after_write", 32'(bus.fifo_count), 32'd1);
        check("lat_tx_idle_after_write", 32'(bus.tx), 32'd1);
        check("lat_busy_after_write", 32'(bus.busy), 32'd1);
        tick();
        check("lat_tx_start", 32'(bus.tx), 32'd0);
        check("lat_count_after_pop", 32'(bus.fifo_count), 32'd0);
        capture(WORD_CYC);
        check("lat_busy_last_cycle", 32'(cap_busy[WORD_CYC-1]), 32'd1);
        check("lat_busy_drop", 32'(bus.busy), 32'd0);
        build_expected(32'h0000_00A5, 0);
        compare_wave("lat_waveform_first_bad_cycle", WORD_CYC);

        // Table of single words: decode bytes, stop bits, parity, full waveform.
        for (int v = 0; v < 5; v++) begin
            tick();
            do_write(vecs[v].data);
            tick();
            capture(WORD_CYC);
            check($sformatf("v%0d_busy_drop", v), 32'(bus.busy), 32'd0);
            for (int j = 0; j < 4; j++) begin
                case (j)
                    0:       exp_b = vecs[v].b0;
                    1:       exp_b = vecs[v].b1;
                    2:       exp_b = vecs[v].b2;
                    default: exp_b = vecs[v].b3;
                endcase
                check($sformatf("v%0d_byte%0d", v, j), 32'(decode_byte(j)), 32'(exp_b));
                check($sformatf("v%0d_stop%0d", v, j),
                      32'(cap_tx[j*BYTE_CYC + BYTE_CYC - N + N/2]), 32'd1);
`ifdef OUTPORT_UART_PARITY_EN
                check($sformatf("v%0d_parity%0d", v, j),
                      32'(cap_tx[j*BYTE_CYC + 9*N + N/2]), 32'(vecs[v].par[j]));
`endif
            end
            build_expected(vecs[v].data, 0);
            compare_wave($sformatf("v%0d_waveform_first_bad_cycle", v), WORD_CYC);
        end

        // Back-to-back words: no gap, busy for exactly two word times.
        tick();
        do_write(32'hFFFF_FFFF);
        do_write(32'h0000_0000);
        check("b2b_count", 32'(bus.fifo_count), 32'd1);
        capture(2 * WORD_CYC);
        check("b2b_busy_drop", 32'(bus.busy), 32'd0);
        busy_cycles = 0;
        for (int i = 0; i < 2 * WORD_CYC; i++) busy_cycles += int'(cap_busy[i]);
        check("b2b_busy_cycles", 32'(busy_cycles), 32'(2 * WORD_CYC));
        build_expected(32'hFFFF_FFFF, 0);
        build_expected(32'h0000_0000, WORD_CYC);
        compare_wave("b2b_waveform_first_bad_cycle", 2 * WORD_CYC);

        // Overflow: six writes while idle; first is popped, four stored, sixth dropped.
        tick();
        for (int i = 0; i < 6; i++) do_write(32'h1000_0000 + 32'(i));
        check("ovf_count", 32'(bus.fifo_count), 32'd4);
        check("ovf_full", 32'(bus.fifo_full), 32'd1);
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        check("ovf_status", bus.status_word, 32'h0000_00E4);
        check("ovf_tx_in_frame", 32'(bus.tx), 32'd0);

        // Reset mid-frame: line idles at once and queued words are discarded.
        repeat (44) tick();
        clear = 1'b0;
        tick();
        clear = 1'b1;
        check("midrst_tx", 32'(bus.tx), 32'd1);
        check("midrst_count", 32'(bus.fifo_count), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_ovf", 32'(bus.overflow), 32'd0);
        check("midrst_status", bus.status_word, 32'd0);
        activity = 0;
        for (int i = 0; i < 300; i++) begin
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) activity++;
            tick();
        end
        check("midrst_no_activity", 32'(activity), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
